wd_bus_sequencer: RTL and testbench

- Bus master for the watchdog's ABUS/DBUS write port.
- Arbitrates between two requesters, a host configuration port (CFG) and a service-kick port (SVC), and serializes their writes.
- Wraps every write in the watchdog's unlock protocol: a pattern cycle, then a data cycle, then a gap.
- Sits between the system controller and the watchdog top level, and stops issuing writes while WDFAIL is asserted.

---
 rtl/wd_bus_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_wd_bus_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wd_bus_sequencer.sv
// wd_bus_sequencer: bus master for the watchdog ABUS/DBUS write port.
// Arbitrates round-robin between a host configuration port (CFG) and a
// service-kick port (SVC), and wraps each write in the unlock protocol:
// pattern cycle, data cycle, gap cycle (ACK). WDFAIL blocks new grants and
// aborts an in-flight write with ERR.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-low reset
//   CFG_REQ/ADDR/DATA   host write request (level), address, data
//   CFG_ACK, CFG_ERR    one-cycle completion / abort pulses for CFG
//   SVC_REQ             service write request (level)
//   SVC_ACK, SVC_ERR    one-cycle completion / abort pulses for SVC
//   WDFAIL              watchdog failure flag
//   ABUS, DBUS          watchdog address / data bus (registered)
//   BUSY                high while a write is in progress
//
// Optional build macro WD_AUTO_SERVICE_EN: an internal free-running counter
// raises a service request every SVC_PERIOD clocks.
module wd_bus_sequencer #(
   parameter logic [7:0]  UNLOCK_PATTERN = 8'hA5,
   parameter logic [7:0]  IDLE_DATA      = 8'h00,
   parameter logic [1:0]  SVC_ADDR       = 2'b11,
   parameter logic [7:0]  SVC_DATA       = 8'h01,
   parameter logic [15:0] SVC_PERIOD     = 16'd1000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CFG_REQ,
   input  logic [1:0] CFG_ADDR,
   input  logic [7:0] CFG_DATA,
   output logic       CFG_ACK,
   output logic       CFG_ERR,
   input  logic       SVC_REQ,
   output logic       SVC_ACK,
   output logic       SVC_ERR,
   input  logic       WDFAIL,
   output logic [1:0] ABUS,
   output logic [7:0] DBUS,
   output logic       BUSY
);

   localparam int unsigned AW = 2;
   localparam int unsigned DW = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_UNLOCK = 2'd1,
      ST_WRITE  = 2'd2,
      ST_GAP    = 2'd3
   } state_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   state_t        state, state_nx;
   wr_t           wr, wr_nx;
   logic          owner_svc, owner_svc_nx;   // 1: current write belongs to SVC
   logic          prio_svc, prio_svc_nx;     // 1: SVC wins a tie
   logic [AW-1:0] abus_nx;
   logic [DW-1:0] dbus_nx;
   logic          busy_nx, cfg_ack_nx, cfg_err_nx, svc_ack_nx, svc_err_nx;

   logic          svc_req_c;
   logic          grant_c;
   logic          pick_svc_c;

   // Service request source: external port, optionally OR-ed with auto-service
`ifdef WD_AUTO_SERVICE_EN
   logic [15:0] svc_cnt;
   logic        svc_pend;
   logic        svc_wrap_c;

   assign svc_wrap_c = (svc_cnt == 16'(SVC_PERIOD - 16'd1));
   assign svc_req_c  = SVC_REQ | svc_pend;

   // Period counter holds during WDFAIL; a wrap while pending is dropped
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         svc_cnt  <= 16'd0;
         svc_pend <= 1'b0;
      end else begin
         if (!WDFAIL) begin
            svc_cnt <= svc_wrap_c ? 16'd0 : 16'(svc_cnt + 16'd1);
         end
         if (!WDFAIL && svc_wrap_c) begin
            svc_pend <= 1'b1;
         end else if (grant_c && pick_svc_c) begin
            svc_pend <= 1'b0;
         end
      end
   end
`else
   logic unused_svc_period;
   assign unused_svc_period = ^SVC_PERIOD;
   assign svc_req_c         = SVC_REQ;
`endif

   // Arbitration: single request wins outright; a tie goes to prio_svc
   assign grant_c    = (state == ST_IDLE) && !WDFAIL && (CFG_REQ || svc_req_c);
   assign pick_svc_c = svc_req_c && (!CFG_REQ || prio_svc);

   // State and registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= ST_IDLE;
         wr        <= '0;
         owner_svc <= 1'b0;
         prio_svc  <= 1'b1;
         ABUS      <= '0;
         DBUS      <= IDLE_DATA;
         BUSY      <= 1'b0;
         CFG_ACK   <= 1'b0;
         CFG_ERR   <= 1'b0;
         SVC_ACK   <= 1'b0;
         SVC_ERR   <= 1'b0;
      end else begin
         state     <= state_nx;
         wr        <= wr_nx;
         owner_svc <= owner_svc_nx;
         prio_svc  <= prio_svc_nx;
         ABUS      <= abus_nx;
         DBUS      <= dbus_nx;
         BUSY      <= busy_nx;
         CFG_ACK   <= cfg_ack_nx;
         CFG_ERR   <= cfg_err_nx;
         SVC_ACK   <= svc_ack_nx;
         SVC_ERR   <= svc_err_nx;
      end
   end

   // Next state plus next-cycle bus/handshake values
   always_comb begin
      state_nx     = state;
      wr_nx        = wr;
      owner_svc_nx = owner_svc;
      prio_svc_nx  = prio_svc;
      abus_nx      = '0;
      dbus_nx      = IDLE_DATA;
      busy_nx      = 1'b0;
      cfg_ack_nx   = 1'b0;
      cfg_err_nx   = 1'b0;
      svc_ack_nx   = 1'b0;
      svc_err_nx   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (grant_c) begin
               state_nx     = ST_UNLOCK;
               owner_svc_nx = pick_svc_c;
               prio_svc_nx  = !pick_svc_c;
               wr_nx        = pick_svc_c ? '{addr: SVC_ADDR, data: SVC_DATA}
                                         : '{addr: CFG_ADDR, data: CFG_DATA};
               dbus_nx      = UNLOCK_PATTERN;
               busy_nx      = 1'b1;
            end
         end
         ST_UNLOCK: begin
            if (WDFAIL) begin
               state_nx   = ST_IDLE;
               cfg_err_nx = !owner_svc;
               svc_err_nx = owner_svc;
            end else begin
               state_nx = ST_WRITE;
               abus_nx  = wr.addr;
               dbus_nx  = wr.data;
               busy_nx  = 1'b1;
            end
         end
         ST_WRITE: begin
            if (WDFAIL) begin
               state_nx   = ST_IDLE;
               cfg_err_nx = !owner_svc;
               svc_err_nx = owner_svc;
            end else begin
               state_nx   = ST_GAP;
               busy_nx    = 1'b1;
               cfg_ack_nx = !owner_svc;
               svc_ack_nx = owner_svc;
            end
         end
         ST_GAP: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_wd_bus_sequencer.sv
// Testbench for wd_bus_sequencer: directed cycle table, asynchronous reset
// corner, then randomized traffic against a transaction-level reference model.
module tb_wd_bus_sequencer;

   logic       CLK = 1'b0;
   logic       RST;
   logic       CFG_REQ;
   logic [1:0] CFG_ADDR;
   logic [7:0] CFG_DATA;
   logic       CFG_ACK, CFG_ERR;
   logic       SVC_REQ;
   logic       SVC_ACK, SVC_ERR;
   logic       WDFAIL;
   logic [1:0] ABUS;
   logic [7:0] DBUS;
   logic       BUSY;

   int errors = 0;
   int checks = 0;

   wd_bus_sequencer dut (
      .CLK(CLK), .RST(RST),
      .CFG_REQ(CFG_REQ), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
      .CFG_ACK(CFG_ACK), .CFG_ERR(CFG_ERR),
      .SVC_REQ(SVC_REQ), .SVC_ACK(SVC_ACK), .SVC_ERR(SVC_ERR),
      .WDFAIL(WDFAIL), .ABUS(ABUS), .DBUS(DBUS), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   // ---------------- reference model (cycles since grant) ----------------
   int       m_age;         // 0: no write in flight, else cycles since grant
   bit       m_svc;         // owner of write in flight
   bit       m_last_svc;    // last granted requester
   bit [1:0] m_addr;
   bit [7:0] m_data;
   bit [1:0] e_abus;
   bit [7:0] e_dbus;
   bit       e_busy, e_cack, e_cerr, e_sack, e_serr;

   function automatic void model_reset();
      m_age = 0; m_svc = 0; m_last_svc = 0;
      m_addr = 0; m_data = 0;
      e_abus = 0; e_dbus = 8'h00; e_busy = 0;
      e_cack = 0; e_cerr = 0; e_sack = 0; e_serr = 0;
   endfunction

   // Advance model by one clock edge using the inputs present at that edge
   function automatic void model_edge();
      e_abus = 0; e_dbus = 8'h00; e_busy = 0;
      e_cack = 0; e_cerr = 0; e_sack = 0; e_serr = 0;
      if (m_age == 0) begin
         if (!WDFAIL && (CFG_REQ || SVC_REQ)) begin
            m_svc      = SVC_REQ && (!CFG_REQ || !m_last_svc);
            m_last_svc = m_svc;
            m_addr     = m_svc ? 2'b11 : CFG_ADDR;
            m_data     = m_svc ? 8'h01 : CFG_DATA;
            m_age      = 1;
            e_dbus     = 8'hA5;
            e_busy     = 1;
         end
      end else if (m_age < 3 && WDFAIL) begin
         m_age = 0;
         if (m_svc) e_serr = 1; else e_cerr = 1;
      end else if (m_age == 1) begin
         m_age = 2; e_abus = m_addr; e_dbus = m_data; e_busy = 1;
      end else if (m_age == 2) begin
         m_age = 3; e_busy = 1;
         if (m_svc) e_sack = 1; else e_cack = 1;
      end else begin
         m_age = 0;
      end
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input bit [1:0] ea, input bit [7:0] ed,
                          input bit eb, input bit eca, input bit ece,
                          input bit esa, input bit ese);
      chk({tag, ".ABUS"},    8'(ABUS),    8'(ea));
      chk({tag, ".DBUS"},    DBUS,        ed);
      chk({tag, ".BUSY"},    8'(BUSY),    8'(eb));
      chk({tag, ".CFG_ACK"}, 8'(CFG_ACK), 8'(eca));
      chk({tag, ".CFG_ERR"}, 8'(CFG_ERR), 8'(ece));
      chk({tag, ".SVC_ACK"}, 8'(SVC_ACK), 8'(esa));
      chk({tag, ".SVC_ERR"}, 8'(SVC_ERR), 8'(ese));
   endtask

   task automatic chk_model(input string tag);
      chk_all(tag, e_abus, e_dbus, e_busy, e_cack, e_cerr, e_sack, e_serr);
   endtask

   // One clock: edge, model update, sample 1ns later
   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit       cfg; bit [1:0] ca; bit [7:0] cd; bit svc; bit wf;
      bit [1:0] ea;  bit [7:0] ed; bit eb; bit eca; bit ece; bit esa; bit ese;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit cfg, bit [1:0] ca, bit [7:0] cd, bit svc, bit wf,
                               bit [1:0] ea, bit [7:0] ed, bit eb,
                               bit eca, bit ece, bit esa, bit ese);
      vec_t v;
      v.cfg = cfg; v.ca = ca; v.cd = cd; v.svc = svc; v.wf = wf;
      v.ea = ea; v.ed = ed; v.eb = eb;
      v.eca = eca; v.ece = ece; v.esa = esa; v.ese = ese;
      tbl.push_back(v);
   endfunction

   initial begin
      // inputs for one cycle -> outputs after the following edge
      //   cfg ca     cd     svc wf   ea     ed     bsy cak cer sak ser
      // CFG write 01/3C; data changes after grant
      add(1, 2'b01, 8'h3C, 0, 0,  2'b00, 8'hA5, 1, 0, 0, 0, 0);
      add(1, 2'b01, 8'h5A, 0, 0,  2'b01, 8'h3C, 1, 0, 0, 0, 0);
      add(1, 2'b01, 8'h5A, 0, 0,  2'b00, 8'h00, 1, 1, 0, 0, 0);
      add(0, 2'b01, 8'h5A, 0, 0,  2'b00, 8'h00, 0, 0, 0, 0, 0);
      // simultaneous requests: SVC first, CFG four cycles later
      add(1, 2'b10, 8'h77, 1, 0,  2'b00, 8'hA5, 1, 0, 0, 0, 0);
      add(1, 2'b10, 8'h77, 1, 0,  2'b11, 8'h01, 1, 0, 0, 0, 0);
      add(1, 2'b10, 8'h77, 1, 0,  2'b00, 8'h00, 1, 0, 0, 1, 0);
      add(1, 2'b10, 8'h77, 1, 0,  2'b00, 8'h00, 0, 0, 0, 0, 0);
      add(1, 2'b10, 8'h77, 0, 0,  2'b00, 8'hA5, 1, 0, 0, 0, 0);
      add(1, 2'b10, 8'h77, 0, 0,  2'b10, 8'h77, 1, 0, 0, 0, 0);
      add(1, 2'b10, 8'h77, 0, 0,  2'b00, 8'h00, 1, 1, 0, 0, 0);
      add(0, 2'b10, 8'h77, 0, 0,  2'b00, 8'h00, 0, 0, 0, 0, 0);
      // both again: last grant was CFG so SVC, then SVC re-requests and CFG wins
      add(1, 2'b10, 8'h77, 1, 0,  2'b00, 8'hA5, 1, 0, 0, 0, 0);
      add(1, 2'b10, 8'h77, 1, 0,  2'b11, 8'h01, 1, 0, 0, 0, 0);
      add(1, 2'b10, 8'h77, 1, 0,  2'b00, 8'h00, 1, 0, 0, 1, 0);
      add(1, 2'b10, 8'h77, 1, 0,  2'b00, 8'h00, 0, 0, 0, 0, 0);
      add(1, 2'b10, 8'h77, 1, 0,  2'b00, 8'hA5, 1, 0, 0, 0, 0);
      add(1, 2'b10, 8'h77, 1, 0,  2'b10, 8'h77, 1, 0, 0, 0, 0);
      add(1, 2'b10, 8'h77, 1, 0,  2'b00, 8'h00, 1, 1, 0, 0, 0);
      add(1, 2'b10, 8'h77, 1, 0,  2'b00, 8'h00, 0, 0, 0, 0, 0);
      add(0, 2'b10, 8'h77, 1, 0,  2'b00, 8'hA5, 1, 0, 0, 0, 0);
      add(0, 2'b10, 8'h77, 1, 0,  2'b11, 8'h01, 1, 0, 0, 0, 0);
      add(0, 2'b10, 8'h77, 1, 0,  2'b00, 8'h00, 1, 0, 0, 1, 0);
      add(0, 2'b10, 8'h77, 0, 0,  2'b00, 8'h00, 0, 0, 0, 0, 0);
      // WDFAIL during CFG WRITE -> ERR, then SVC blocked while WDFAIL high
      add(1, 2'b01, 8'hC3, 0, 0,  2'b00, 8'hA5, 1, 0, 0, 0, 0);
      add(1, 2'b01, 8'hC3, 0, 0,  2'b01, 8'hC3, 1, 0, 0, 0, 0);
      add(1, 2'b01, 8'hC3, 0, 1,  2'b00, 8'h00, 0, 0, 1, 0, 0);
      add(0, 2'b01, 8'hC3, 1, 1,  2'b00, 8'h00, 0, 0, 0, 0, 0);
      add(0, 2'b01, 8'hC3, 1, 1,  2'b00, 8'h00, 0, 0, 0, 0, 0);
      add(0, 2'b01, 8'hC3, 1, 0,  2'b00, 8'hA5, 1, 0, 0, 0, 0);
      add(0, 2'b01, 8'hC3, 1, 0,  2'b11, 8'h01, 1, 0, 0, 0, 0);
      add(0, 2'b01, 8'hC3, 1, 0,  2'b00, 8'h00, 1, 0, 0, 1, 0);
      add(0, 2'b01, 8'hC3, 0, 0,  2'b00, 8'h00, 0, 0, 0, 0, 0);
      // WDFAIL rising in GAP: ACK already issued, no ERR
      add(1, 2'b00, 8'h11, 0, 0,  2'b00, 8'hA5, 1, 0, 0, 0, 0);
      add(1, 2'b00, 8'h11, 0, 0,  2'b00, 8'h11, 1, 0, 0, 0, 0);
      add(1, 2'b00, 8'h11, 0, 0,  2'b00, 8'h00, 1, 1, 0, 0, 0);
      add(1, 2'b00, 8'h11, 0, 1,  2'b00, 8'h00, 0, 0, 0, 0, 0);
      add(0, 2'b00, 8'h11, 0, 0,  2'b00, 8'h00, 0, 0, 0, 0, 0);
      // WDFAIL during SVC UNLOCK -> SVC_ERR
      add(0, 2'b00, 8'h11, 1, 0,  2'b00, 8'hA5, 1, 0, 0, 0, 0);
      add(0, 2'b00, 8'h11, 1, 1,  2'b00, 8'h00, 0, 0, 0, 0, 1);
      add(0, 2'b00, 8'h11, 0, 0,  2'b00, 8'h00, 0, 0, 0, 0, 0);
      // CFG held after ACK -> second write granted in cycle 4
      add(1, 2'b11, 8'hE7, 0, 0,  2'b00, 8'hA5, 1, 0, 0, 0, 0);
      add(1, 2'b11, 8'hE7, 0, 0,  2'b11, 8'hE7, 1, 0, 0, 0, 0);
      add(1, 2'b11, 8'hE7, 0, 0,  2'b00, 8'h00, 1, 1, 0, 0, 0);
      add(1, 2'b11, 8'hE7, 0, 0,  2'b00, 8'h00, 0, 0, 0, 0, 0);
      add(1, 2'b11, 8'hE7, 0, 0,  2'b00, 8'hA5, 1, 0, 0, 0, 0);
      add(1, 2'b11, 8'hE7, 0, 0,  2'b11, 8'hE7, 1, 0, 0, 0, 0);
      add(1, 2'b11, 8'hE7, 0, 0,  2'b00, 8'h00, 1, 1, 0, 0, 0);
      add(0, 2'b11, 8'hE7, 0, 0,  2'b00, 8'h00, 0, 0, 0, 0, 0);

      // ---------------- reset state ----------------
      RST = 1'b0; CFG_REQ = 0; CFG_ADDR = 0; CFG_DATA = 0; SVC_REQ = 0; WDFAIL = 0;
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      chk_all("reset", 2'b00, 8'h00, 0, 0, 0, 0, 0);
      @(negedge CLK);
      RST = 1'b1;
      step();
      chk_all("post_reset_idle", 2'b00, 8'h00, 0, 0, 0, 0, 0);

      // ---------------- directed table ----------------
      for (int i = 0; i < tbl.size(); i++) begin
         CFG_REQ = tbl[i].cfg; CFG_ADDR = tbl[i].ca; CFG_DATA = tbl[i].cd;
         SVC_REQ = tbl[i].svc; WDFAIL = tbl[i].wf;
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].ea, tbl[i].ed, tbl[i].eb,
                 tbl[i].eca, tbl[i].ece, tbl[i].esa, tbl[i].ese);
      end

      // ---------------- asynchronous reset during UNLOCK ----------------
      CFG_REQ = 1; CFG_ADDR = 2'b10; CFG_DATA = 8'h99;
      step();
      chk_all("rst_pre_unlock", 2'b00, 8'hA5, 1, 0, 0, 0, 0);
      #2;
      RST = 1'b0; CFG_REQ = 0;
      #1;
      chk_all("rst_async", 2'b00, 8'h00, 0, 0, 0, 0, 0);
      model_reset();
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_all($sformatf("rst_after%0d", i), 2'b00, 8'h00, 0, 0, 0, 0, 0);
      end

      // ---------------- randomized traffic vs model ----------------
      for (int i = 0; i < 600; i++) begin
         CFG_REQ  = ($urandom_range(0, 2) != 0);
         CFG_ADDR = 2'($urandom_range(0, 3));
         CFG_DATA = 8'($urandom_range(0, 255));
         SVC_REQ  = ($urandom_range(0, 2) == 0);
         WDFAIL   = ($urandom_range(0, 9) == 0);
         step();
         chk_model($sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
